// File: rtl/board_store.sv
// Banqi 4x8 board storage: deals a shuffled covered layout, then accepts
// single-square writes and reports per-colour piece counts and game-over.
module board_store #(
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter int unsigned SWAP_COUNT = 64
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         new_game,
   input  logic         wr_en,
   input  logic [4:0]   wr_addr,
   input  logic [4:0]   wr_piece,
   output logic [159:0] board_out,
   output logic         ready,
   output logic         wr_dropped,
   output logic [4:0]   red_count,
   output logic [4:0]   black_count,
   output logic         game_over
);

   typedef enum logic [1:0] {S_FILL, S_SHUFFLE, S_READY} state_t;

   localparam logic [15:0] SEED_EFF  = (SEED == 16'h0) ? 16'hACE1 : SEED;
   localparam logic [7:0]  LAST_SWAP = 8'(SWAP_COUNT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_board [32];
   logic [4:0]  r_idx;
   logic [7:0]  r_swaps;
   logic [15:0] r_lfsr;
   logic [4:0]  r_red;
   logic [4:0]  r_black;
   logic        r_go;
   logic        r_drop;

   logic        w_fb;
   logic [4:0]  w_a;
   logic [4:0]  w_b;
   logic [2:0]  w_type;
   logic [4:0]  w_canon;
   logic [5:0]  w_red;
   logic [5:0]  w_black;
   logic [4:0]  w_red_sat;
   logic [4:0]  w_black_sat;
   logic        w_wr_ok;

   assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_a     = r_lfsr[4:0];
   assign w_b     = r_lfsr[9:5];
   assign w_wr_ok = (r_state == S_READY) && wr_en && !new_game;

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= S_FILL;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_FILL:    if (r_idx == 5'd31)        w_next = S_SHUFFLE;
         S_SHUFFLE: if (r_swaps == LAST_SWAP)  w_next = S_READY;
         S_READY:   if (new_game)              w_next = S_FILL;
         default:                              w_next = S_FILL;
      endcase
   end

   always_comb begin
      ready = (r_state == S_READY);
   end

   // Canonical order: 5 soldiers, 2 each cannon..queen, 1 king per colour
   always_comb begin
      w_type = 3'd7;
      if      (r_idx[3:0] < 4'd5)  w_type = 3'd1;
      else if (r_idx[3:0] < 4'd7)  w_type = 3'd2;
      else if (r_idx[3:0] < 4'd9)  w_type = 3'd3;
      else if (r_idx[3:0] < 4'd11) w_type = 3'd4;
      else if (r_idx[3:0] < 4'd13) w_type = 3'd5;
      else if (r_idx[3:0] < 4'd15) w_type = 3'd6;
   end

   assign w_canon = {r_idx[4], w_type, 1'b0};

   // Colour bit 0 = red, 1 = black
   always_comb begin
      w_red   = '0;
      w_black = '0;
      for (int i = 0; i < 32; i++) begin
         if (r_board[i][3:1] != 3'b000) begin
            if (r_board[i][4]) w_black = w_black + 6'd1;
            else               w_red   = w_red + 6'd1;
         end
      end
   end

   assign w_red_sat   = w_red[5]   ? 5'd31 : w_red[4:0];
   assign w_black_sat = w_black[5] ? 5'd31 : w_black[4:0];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < 32; i++) r_board[i] <= '0;
         r_idx   <= '0;
         r_swaps <= '0;
         r_lfsr  <= SEED_EFF;
         r_red   <= '0;
         r_black <= '0;
         r_go    <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_fb};
         r_drop <= wr_en && !w_wr_ok;
         unique case (r_state)
            S_FILL: begin
               r_board[r_idx] <= w_canon;
               r_idx          <= r_idx + 5'd1;
            end
            S_SHUFFLE: begin
               r_board[w_a] <= r_board[w_b];
               r_board[w_b] <= r_board[w_a];
               r_swaps      <= r_swaps + 8'd1;
            end
            S_READY: begin
               if (w_wr_ok) r_board[wr_addr] <= wr_piece;
               if (new_game) begin
                  r_idx   <= '0;
                  r_swaps <= '0;
               end
            end
            default: ;
         endcase
         // Counts freeze during a deal; swaps never change the popcount
         if (w_next == S_READY) begin
            r_red   <= w_red_sat;
            r_black <= w_black_sat;
            r_go    <= (w_red == 6'd0) || (w_black == 6'd0);
         end else begin
            r_go    <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < 32; g++) begin : g_out
      assign board_out[g*5 +: 5] = r_board[g];
   end

   assign wr_dropped  = r_drop;
   assign red_count   = r_red;
   assign black_count = r_black;
   assign game_over   = r_go;

endmodule

// File: tb/tb_board_store.sv
// Directed bench for board_store: deal model, write table, drop pulses,
// game-over and reset-mid-deal reproducibility.
module tb_board_store;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         new_game;
   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [4:0]   wr_piece;
   logic [159:0] board_out;
   logic         ready;
   logic         wr_dropped;
   logic [4:0]   red_count;
   logic [4:0]   black_count;
   logic         game_over;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct packed {
      logic       we;
      logic [4:0] addr;
      logic [4:0] piece;
      logic       exp_drop;
   } vec_t;

   vec_t tbl [5];

   always #5 CLK = ~CLK;

   board_store dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .new_game   (new_game),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_piece   (wr_piece),
      .board_out  (board_out),
      .ready      (ready),
      .wr_dropped (wr_dropped),
      .red_count  (red_count),
      .black_count(black_count),
      .game_over  (game_over)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string nm, input logic [159:0] act,
                      input logic [159:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   function automatic logic [4:0] canon(input int i);
      logic [2:0] t;
      int k;
      k = i % 16;
      if      (k <= 4)  t = 3'd1;
      else if (k <= 6)  t = 3'd2;
      else if (k <= 8)  t = 3'd3;
      else if (k <= 10) t = 3'd4;
      else if (k <= 12) t = 3'd5;
      else if (k <= 14) t = 3'd6;
      else              t = 3'd7;
      return {(i >= 16) ? 1'b1 : 1'b0, t, 1'b0};
   endfunction

   function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [159:0] model_deal(input logic [15:0] seed);
      logic [4:0]   bd [32];
      logic [15:0]  l;
      logic [4:0]   tmp;
      logic [159:0] r;
      int a, b;
      l = seed;
      for (int i = 0; i < 32; i++) begin
         bd[i] = canon(i);
         l = lfsr_nx(l);
      end
      for (int s = 0; s < 64; s++) begin
         a = int'(l[4:0]);
         b = int'(l[9:5]);
         tmp   = bd[a];
         bd[a] = bd[b];
         bd[b] = tmp;
         l = lfsr_nx(l);
      end
      for (int i = 0; i < 32; i++) r[i*5 +: 5] = bd[i];
      return r;
   endfunction

   function automatic logic [4:0] pop(input logic [159:0] bv, input logic col);
      logic [4:0] p;
      int c;
      c = 0;
      for (int i = 0; i < 32; i++) begin
         p = bv[i*5 +: 5];
         if (p[4] == col && p[3:1] != 3'b000) c++;
      end
      return 5'(c);
   endfunction

   function automatic logic multiset_ok(input logic [159:0] bv);
      int cnt [2][8];
      int want [8];
      logic [4:0] p;
      want = '{0, 5, 2, 2, 2, 2, 2, 1};
      for (int c = 0; c < 2; c++)
         for (int t = 0; t < 8; t++) cnt[c][t] = 0;
      for (int i = 0; i < 32; i++) begin
         p = bv[i*5 +: 5];
         if (p[0]) return 1'b0;
         cnt[int'(p[4])][int'(p[3:1])]++;
      end
      for (int c = 0; c < 2; c++)
         for (int t = 0; t < 8; t++)
            if (cnt[c][t] != want[t]) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      logic [159:0] d1, d2, mb;
      logic [4:0]   pr, pb;
      int           nw;

      tbl[0] = '{we: 1'b1, addr: 5'd9,  piece: 5'b10111, exp_drop: 1'b0};
      tbl[1] = '{we: 1'b1, addr: 5'd2,  piece: 5'b00000, exp_drop: 1'b0};
      tbl[2] = '{we: 1'b0, addr: 5'd5,  piece: 5'b00010, exp_drop: 1'b0};
      tbl[3] = '{we: 1'b1, addr: 5'd31, piece: 5'b00011, exp_drop: 1'b0};
      tbl[4] = '{we: 1'b1, addr: 5'd31, piece: 5'b10001, exp_drop: 1'b0};

      RESET = 1'b1; new_game = 1'b0; wr_en = 1'b0;
      wr_addr = '0; wr_piece = '0;
      d1 = model_deal(16'hACE1);

      // reset state
      step();
      chk("rst_board", board_out, '0);
      chk("rst_ready", ready, 0);
      chk("rst_drop", wr_dropped, 0);
      chk("rst_red", red_count, 0);
      chk("rst_black", black_count, 0);
      chk("rst_go", game_over, 0);
      RESET = 1'b0;

      // first deal
      steps(95);
      chk("deal1_ready_early", ready, 0);
      step();
      chk("deal1_ready", ready, 1);
      chk("deal1_layout", board_out, d1);
      chk("deal1_multiset", multiset_ok(board_out), 1);
      chk("deal1_red", red_count, 16);
      chk("deal1_black", black_count, 16);
      chk("deal1_go", game_over, 0);

      // write table in READY
      mb = d1;
      for (int v = 0; v < 5; v++) begin
         pr = pop(mb, 1'b0);
         pb = pop(mb, 1'b1);
         if (tbl[v].we) mb[int'(tbl[v].addr)*5 +: 5] = tbl[v].piece;
         wr_en    = tbl[v].we;
         wr_addr  = tbl[v].addr;
         wr_piece = tbl[v].piece;
         step();
         chk($sformatf("wr%0d_board", v), board_out, mb);
         chk($sformatf("wr%0d_drop", v), wr_dropped, tbl[v].exp_drop);
         chk($sformatf("wr%0d_red", v), red_count, pr);
         chk($sformatf("wr%0d_black", v), black_count, pb);
      end
      wr_en = 1'b0;
      step();
      chk("wr_red_final", red_count, pop(mb, 1'b0));
      chk("wr_black_final", black_count, pop(mb, 1'b1));

      // write together with new_game: new_game wins
      wr_en = 1'b1; wr_addr = 5'd0; wr_piece = 5'b11111; new_game = 1'b1;
      step();
      wr_en = 1'b0; new_game = 1'b0;
      chk("ng_wr_drop", wr_dropped, 1);
      chk("ng_ready", ready, 0);
      chk("ng_board_unchanged", board_out, mb);
      step();
      chk("ng_wr_drop_clear", wr_dropped, 0);

      // write during SHUFFLE
      steps(39);
      wr_en = 1'b1; wr_addr = 5'd3; wr_piece = 5'b11111;
      step();
      wr_en = 1'b0;
      chk("shuf_wr_drop", wr_dropped, 1);
      chk("shuf_ready", ready, 0);
      step();
      chk("shuf_wr_drop_clear", wr_dropped, 0);
      steps(53);
      chk("deal2_ready_early", ready, 0);
      step();
      chk("deal2_ready", ready, 1);
      chk("deal2_multiset", multiset_ok(board_out), 1);
      chk("deal2_differs", board_out != d1, 1);
      chk("deal2_red", red_count, 16);
      chk("deal2_black", black_count, 16);
      d2 = board_out;

      // erase every red piece, back to back
      mb = d2;
      nw = 0;
      for (int i = 0; i < 32; i++) begin
         if (d2[i*5+4] == 1'b0 && d2[i*5+1 +: 3] != 3'b000) begin
            mb[i*5 +: 5] = 5'b0;
            wr_en = 1'b1; wr_addr = 5'(i); wr_piece = 5'b0;
            step();
            nw++;
         end
      end
      wr_en = 1'b0;
      chk("erase_count", nw, 16);
      chk("erase_red_lag", red_count, 1);
      chk("erase_go_lag", game_over, 0);
      step();
      chk("erase_board", board_out, mb);
      chk("erase_red", red_count, 0);
      chk("erase_black", black_count, 16);
      chk("erase_go", game_over, 1);
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      chk("ng2_go", game_over, 0);
      chk("ng2_ready", ready, 0);
      chk("ng2_drop", wr_dropped, 0);

      // reset mid-SHUFFLE, then reproducible re-deal
      steps(40);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      chk("rst2_board", board_out, '0);
      chk("rst2_ready", ready, 0);
      chk("rst2_go", game_over, 0);
      steps(95);
      chk("deal3_ready_early", ready, 0);
      step();
      chk("deal3_ready", ready, 1);
      chk("deal3_layout", board_out, d1);
      chk("deal3_red", red_count, 16);
      chk("deal3_black", black_count, 16);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
